pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use hazards, handles the data-memory wait-state handshake from the MEM stage, and applies taken branch/jump flushes. It drives the enable and flush/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush control slice.
// - ctrl_state_e : sequencer state encoding (also exposed on state_o for debug)
// - pipe_ctrl_t  : bundle of register enables / flush controls for one cycle
// - Bubble convention: a bubble is an instruction whose control fields are
//   all 0, which in particular means RegWrite = 0. The pipeline-register
//   modules use BUBBLE_CTRL_FIELDS / BUBBLE_REGWRITE when flushing.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd3
  } ctrl_state_e;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;
  localparam int unsigned WAIT_W              = 8;

  localparam logic BUBBLE_REGWRITE    = 1'b0;
  localparam logic BUBBLE_CTRL_FIELDS = 1'b0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } pipe_ctrl_t;

  // Free-running pipeline: everything advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                         exmem_en: 1'b1, memwb_en: 1'b1,
                                         ifid_flush: 1'b0, idex_flush: 1'b0,
                                         memwb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare.
// Ports:
//   idex_memread, idex_rt : load currently in EX and its destination register
//   ifid_rs, ifid_rt      : source registers of the instruction in ID
//   ifid_uses_rt          : ID instruction actually reads rt
//   loaduse               : ID instruction needs the load result next cycle
module hazard_detect (
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       loaduse
);

  // $0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign loaduse = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   idex_memread, idex_rt            : load in EX
//   ifid_rs, ifid_rt, ifid_uses_rt   : operands of the instruction in ID
//   branch_taken_id                  : branch/jump resolved taken in ID
//   exmem_memread, exmem_memwrite    : MEM stage holds a memory access
//   mem_ready                        : data memory completes the access this cycle
//   mem_req                          : access request to data memory
//   pc_en .. memwb_en                : pipeline register load enables
//   ifid_flush, idex_flush           : squash IF/ID, bubble into ID/EX
//   memwb_bubble                     : force RegWrite = 0 into MEM/WB
//   mem_err                          : sticky memory-timeout flag
//   stall_cycles                     : saturating count of cycles with pc_en = 0
//   state_o                          : current sequencer state (debug)
// Handshake: mem_req is held high (with the access inputs stable) until the
// memory answers with mem_ready in the same cycle; mem_ready without an
// outstanding access is ignored.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken_id,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state_o
);

  // Wait counter value on the last tolerated no-ready MEMWAIT cycle; one more
  // miss there means MEM_TIMEOUT wait cycles have elapsed.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              access, memstall, loaduse, in_err;
  pipe_ctrl_t        ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .loaduse      (loaduse)
  );

  assign access   = exmem_memread | exmem_memwrite;
  assign in_err   = (state == ERR);
  assign memstall = access & ~mem_ready & ~in_err;
  assign mem_req  = access & ~in_err & ~reset;

  // Priority: reset > ERR > memstall > loaduse > branch > normal.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (reset) begin
      ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
               memwb_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1, memwb_bubble: 1'b1};
    end else if (in_err) begin
      ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
               memwb_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b1};
    end else if (memstall) begin
      // MEM/WB keeps loading, but with a bubble so WB does not commit twice.
      ctrl = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
               memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b1};
    end else if (loaduse) begin
      // A taken branch in ID is held back here; it re-resolves next cycle.
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (branch_taken_id) begin
      ctrl.ifid_flush = 1'b1;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign state_o      = state;

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      RUN: begin
        wait_next = '0;
        if (memstall) state_next = MEMWAIT;
      end
      MEMWAIT: begin
        if (!memstall) begin
          // Access completed (or withdrawn): pipeline advances this cycle.
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ERR;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == ERR) mem_err <= 1'b1;
      if (!ctrl.pc_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed steps followed by random cycles,
// each cycle checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int SAT     = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          idex_memread, ifid_uses_rt, branch_taken_id;
  logic [4:0]    idex_rt, ifid_rs, ifid_rt;
  logic          exmem_memread, exmem_memwrite, mem_ready;
  logic          mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [CW-1:0] stall_cycles;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  // Reference model state, in terms of the rules rather than the FSM:
  // m_streak = consecutive preceding memory-stall cycles, m_err = frozen,
  // m_stalls = cycles seen with pc_en low (saturating).
  int   m_streak = 0;
  bit   m_err    = 0;
  int   m_stalls = 0;
  logic [8:0] exp_q[$];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken_id(branch_taken_id),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Expected control vector:
  // {mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [8:0] model_ctrl();
    logic acc, lu;
    acc = exmem_memread | exmem_memwrite;
    lu  = idex_memread && idex_rt != 0 &&
          (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    if (reset)                  return 9'b0_00000_111;
    if (m_err)                  return 9'b0_00000_001;
    if (acc && !mem_ready)      return 9'b1_00001_001;
    if (lu)                     return {acc, 8'b00111_010};
    if (branch_taken_id)        return {acc, 8'b11111_100};
    return {acc, 8'b11111_000};
  endfunction

  function automatic logic [1:0] model_state();
    if (m_err)        return 2'd3;
    if (m_streak > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict, compare away from the edge, then advance the model.
  task automatic step();
    logic [8:0] e;
    logic [8:0] got;
    e = model_ctrl();
    exp_q.push_back(e);
    @(negedge clk);
    got = {mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble};
    check("ctrl", 16'(got), 16'(exp_q.pop_front()));
    check("state", 16'(state_o), 16'(model_state()));
    check("mem_err", 16'(mem_err), 16'(m_err));
    check("stall_cycles", 16'(stall_cycles), 16'(m_stalls));
    @(posedge clk);
    if (reset) begin
      m_err = 0; m_streak = 0; m_stalls = 0;
    end else begin
      if (!e[7] && m_stalls < SAT) m_stalls++;
      if (!m_err) begin
        if ((exmem_memread | exmem_memwrite) && !mem_ready) begin
          m_streak++;
          // The first stall cycle is spent in RUN; ERR follows TIMEOUT waits.
          if (m_streak == TIMEOUT + 1) begin
            m_err = 1; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    branch_taken_id = 0; exmem_memread = 0; exmem_memwrite = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;

    // Reset state
    step();
    reset = 0;
    step();

    // Load-use: lw $8 in EX, add reading rs = 8 in ID -> one bubble
    do_reset();
    idex_memread = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 3; ifid_uses_rt = 1;
    step();
    idle_inputs(); step();
    check("loaduse_stalls", 16'(stall_cycles), 16'd1);

    // Load-use through rt, and rt not read -> no stall
    idex_memread = 1; idex_rt = 5; ifid_rs = 1; ifid_rt = 5; ifid_uses_rt = 1; step();
    ifid_uses_rt = 0; step();

    // $0 destination -> no stall
    idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 1; step();

    // Memory wait: 3 cycles not ready, then ready
    do_reset();
    exmem_memread = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1; step();
    idle_inputs(); step();
    check("memwait_stalls", 16'(stall_cycles), 16'd3);

    // Zero-wait store
    exmem_memwrite = 1; mem_ready = 1; step();
    idle_inputs(); step();

    // Load-use + branch: only the stall; then the branch flushes
    do_reset();
    idex_memread = 1; idex_rt = 9; ifid_rs = 9; branch_taken_id = 1; step();
    idex_memread = 0; step();
    idle_inputs();

    // memstall + loaduse: memory stall wins
    idex_memread = 1; idex_rt = 9; ifid_rs = 9; exmem_memread = 1; mem_ready = 0; step();
    mem_ready = 1; step();
    idle_inputs(); step();

    // Timeout into ERR, then reset out of it
    do_reset();
    exmem_memread = 1; mem_ready = 0;
    repeat (TIMEOUT + 3) step();
    check("timeout_err", 16'(mem_err), 16'd1);
    check("timeout_state", 16'(state_o), 16'd3);
    mem_ready = 1; step();
    do_reset();
    check("post_reset_state", 16'(state_o), 16'd0);
    check("post_reset_err", 16'(mem_err), 16'd0);
    check("post_reset_stalls", 16'(stall_cycles), 16'd0);

    // Saturation: 20 load-use stall cycles on a 4-bit counter
    idex_memread = 1; idex_rt = 4; ifid_rs = 4;
    repeat (20) step();
    idle_inputs(); step();
    check("saturate", 16'(stall_cycles), 16'(SAT));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset           = (m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0;
      idex_memread    = 1'($urandom_range(0, 1));
      idex_rt         = 5'($urandom_range(0, 3));
      ifid_rs         = 5'($urandom_range(0, 3));
      ifid_rt         = 5'($urandom_range(0, 3));
      ifid_uses_rt    = 1'($urandom_range(0, 1));
      branch_taken_id = ($urandom_range(0, 3) == 0);
      exmem_memread   = ($urandom_range(0, 2) == 0);
      exmem_memwrite  = ($urandom_range(0, 4) == 0);
      mem_ready       = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
